// File: rtl/aes_shift_mix_stage.sv
// AES round-tail stage: ShiftRows -> MixColumns (skipped on final round) -> AddRoundKey,
// presented on a valid/ready stream through an output register plus skid buffer.
// Optional macro AES_MIX_PIPE_EN: adds a register between MixColumns and AddRoundKey
// (latency 2) and deepens the skid buffer to two entries.
// Byte k of a state is data[127-8k -: 8]; s[r][c] is byte 4c+r (column-major).
module aes_shift_mix_stage #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_key,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  generate
    if (DATA_W != 128) begin : g_bad_width
      $error("aes_shift_mix_stage: DATA_W must be 128");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // One MixColumns column; a0 is the most significant byte of the word.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Row r rotates left by r columns: s'[r][c] = s[r][(c+r) mod 4].
  function automatic logic [DATA_W-1:0] shift_rows(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] q;
    q = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        q[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)&3)+r) -: 8];
      end
    end
    return q;
  endfunction

  function automatic logic [DATA_W-1:0] mix_columns(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] q;
    q = '0;
    for (int c = 0; c < 4; c++) begin
      q[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return q;
  endfunction

  logic              w_acc;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_mixed;

  logic              w_st_valid;
  logic [DATA_W-1:0] w_st_data;
  logic              w_st_last;
  logic              w_rdy_nxt;

  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [1:0]        r_skid_cnt;
  logic [DATA_W-1:0] r_skid0_data;
  logic              r_skid0_last;
  logic [DATA_W-1:0] r_skid1_data;
  logic              r_skid1_last;

  logic              w_out_free;
  logic              w_out_valid_nxt;
  logic [1:0]        w_cnt_nxt;
  logic              w_ld_out_skid;
  logic              w_ld_out_st;
  logic              w_sk0_from_st;
  logic              w_sk0_from_sk1;
  logic              w_sk1_from_st;

  assign w_acc     = in_valid & r_in_ready;
  assign w_shifted = shift_rows(in_data);
  assign w_mixed   = in_last ? w_shifted : mix_columns(w_shifted);

`ifdef AES_MIX_PIPE_EN
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_mix_p1;
  logic [DATA_W-1:0] r_key_p1;
  logic              r_last_p1;

  // Stage p1 valid: the mixed state always advances; the skid has room reserved for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= w_acc;
  end

  // Stage p1 payload: mixed state travels with its round key and last flag.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mix_p1  <= w_mixed;
      r_key_p1  <= in_key;
      r_last_p1 <= in_last;
    end
  end

  assign w_st_valid = r_vld_p1;
  assign w_st_data  = r_mix_p1 ^ r_key_p1;
  assign w_st_last  = r_last_p1;
  // The in-flight p1 entry counts against the two skid slots so it can always land.
  assign w_rdy_nxt  = ({1'b0, w_cnt_nxt} + {2'b00, w_acc}) < 3'd2;
  assign busy       = r_out_valid | (r_skid_cnt != 2'd0) | r_vld_p1;
`else
  assign w_st_valid = w_acc;
  assign w_st_data  = w_mixed ^ in_key;
  assign w_st_last  = in_last;
  assign w_rdy_nxt  = (w_cnt_nxt == 2'd0);
  assign busy       = r_out_valid | (r_skid_cnt != 2'd0);
`endif

  // Output-buffer steering: output register is head, skid0/skid1 queue behind it in order.
  always_comb begin
    w_out_free      = ~r_out_valid | out_ready;
    w_out_valid_nxt = r_out_valid;
    w_cnt_nxt       = r_skid_cnt;
    w_ld_out_skid   = 1'b0;
    w_ld_out_st     = 1'b0;
    w_sk0_from_st   = 1'b0;
    w_sk0_from_sk1  = 1'b0;
    w_sk1_from_st   = 1'b0;
    if (w_out_free) begin
      if (r_skid_cnt != 2'd0) begin
        w_ld_out_skid   = 1'b1;
        w_out_valid_nxt = 1'b1;
        if (w_st_valid) begin
          if (r_skid_cnt == 2'd1) begin
            w_sk0_from_st = 1'b1;
          end else begin
            w_sk0_from_sk1 = 1'b1;
            w_sk1_from_st  = 1'b1;
          end
        end else begin
          w_cnt_nxt      = r_skid_cnt - 2'd1;
          w_sk0_from_sk1 = (r_skid_cnt == 2'd2);
        end
      end else begin
        w_ld_out_st     = w_st_valid;
        w_out_valid_nxt = w_st_valid;
      end
    end else if (w_st_valid) begin
      if (r_skid_cnt == 2'd0) w_sk0_from_st = 1'b1;
      else                    w_sk1_from_st = 1'b1;
      w_cnt_nxt = r_skid_cnt + 2'd1;
    end
  end

  // Output stage and buffer occupancy; reset clears every visible output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_skid_cnt  <= 2'd0;
    end else begin
      r_in_ready  <= w_rdy_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_skid_cnt  <= w_cnt_nxt;
      if (w_ld_out_skid) begin
        r_out_data <= r_skid0_data;
        r_out_last <= r_skid0_last;
      end else if (w_ld_out_st) begin
        r_out_data <= w_st_data;
        r_out_last <= w_st_last;
      end
    end
  end

  // Skid payload; occupancy lives in r_skid_cnt so the data needs no reset.
  always_ff @(posedge clk) begin
    if (w_sk0_from_st) begin
      r_skid0_data <= w_st_data;
      r_skid0_last <= w_st_last;
    end else if (w_sk0_from_sk1) begin
      r_skid0_data <= r_skid1_data;
      r_skid0_last <= r_skid1_last;
    end
    if (w_sk1_from_st) begin
      r_skid1_data <= w_st_data;
      r_skid1_last <= w_st_last;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_aes_shift_mix_stage.sv
// Self-checking bench for aes_shift_mix_stage: directed FIPS-197 vectors plus
// backpressure, throughput and reset scenarios against a GF(2^8) reference model.
module tb_aes_shift_mix_stage;

`ifdef AES_MIX_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  aes_shift_mix_stage #(.DATA_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference round tail via explicit state matrix and MixColumns matrix product.
  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k, input logic l);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] u [4][4];
    logic [7:0] cf [4];
    logic [7:0] acc;
    logic [127:0] q;
    cf[0] = 8'd2; cf[1] = 8'd3; cf[2] = 8'd1; cf[3] = 8'd1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = d[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = s[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j-r+4)%4], t[j][c]);
        u[r][c] = l ? t[r][c] : acc;
      end
    q = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        q[127-8*(4*c+r) -: 8] = u[r][c];
    return q ^ k;
  endfunction

  // Send one state with out_ready=1 and capture the first result and its latency.
  task automatic run_one(input logic [127:0] d, input logic [127:0] k, input logic l,
                         output logic [127:0] q, output logic ql, output int lat);
    q = '0; ql = 1'b0; lat = -1;
    out_ready = 1'b1;
    @(negedge clk);
    in_data = d; in_key = k; in_last = l; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (out_valid) begin
        q = out_data; ql = out_last; lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_key    = {$urandom, $urandom, $urandom, $urandom};
      in_last   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 128'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips_round();
    logic [127:0] q; logic ql; int lat;
    run_one(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, q, ql, lat);
    n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL fips_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (q !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin n_bad++; $display("FAIL fips_data: got %h want a49c7ff2689f352b6b5bea43026a5049", q); end
    n_cmp++; if (ql !== 1'b0) begin n_bad++; $display("FAIL fips_last: got %b want 0", ql); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fips_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_mixcolumns();
    logic [127:0] q; logic ql; int lat;
    run_one({4{32'hdb135345}}, 128'h0, 1'b0, q, ql, lat);
    n_cmp++; if (q !== {4{32'h8e4da1bc}}) begin n_bad++; $display("FAIL mixcol_data: got %h want %h", q, {4{32'h8e4da1bc}}); end
    run_one({4{32'hdb135345}}, 128'h0, 1'b1, q, ql, lat);
    n_cmp++; if (q !== {4{32'hdb135345}}) begin n_bad++; $display("FAIL mixcol_last_bypass: got %h want %h", q, {4{32'hdb135345}}); end
    n_cmp++; if (ql !== 1'b1) begin n_bad++; $display("FAIL mixcol_last_flag: got %b want 1", ql); end
  endtask

  task automatic test_shiftrows();
    logic [127:0] q; logic ql; int lat;
    run_one(128'h000102030405060708090a0b0c0d0e0f, 128'h0, 1'b1, q, ql, lat);
    n_cmp++; if (q !== 128'h00050a0f04090e03080d02070c01060b) begin n_bad++; $display("FAIL shiftrows_data: got %h want 00050a0f04090e03080d02070c01060b", q); end
    n_cmp++; if (ql !== 1'b1) begin n_bad++; $display("FAIL shiftrows_last: got %b want 1", ql); end
  endtask

  task automatic test_backpressure();
    logic [127:0] d [8];
    logic [127:0] k [8];
    logic         l [8];
    logic [127:0] exp_d [8];
    logic [127:0] held_d;
    logic         held_l;
    logic         prev_stall, saw_full;
    int tx, rx;
    for (int i = 0; i < 8; i++) begin
      d[i] = {$urandom, $urandom, $urandom, $urandom};
      k[i] = {$urandom, $urandom, $urandom, $urandom};
      l[i] = (i % 3 == 2);
      exp_d[i] = ref_round(d[i], k[i], l[i]);
    end
    tx = 0; rx = 0; prev_stall = 1'b0; saw_full = 1'b0; held_d = '0; held_l = 1'b0;
    for (int cyc = 0; cyc < 400 && rx < 8; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_cmp++;
        if (out_data !== held_d || out_last !== held_l) begin
          n_bad++; $display("FAIL bp_stable: got %h/%b want %h/%b", out_data, out_last, held_d, held_l);
        end
      end
      out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      if (tx < 8) begin
        in_valid = 1'b1; in_data = d[tx]; in_key = k[tx]; in_last = l[tx];
      end else begin
        in_valid = 1'b0;
      end
      if (!in_ready) saw_full = 1'b1;
      if (in_valid && in_ready) tx++;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== exp_d[rx] || out_last !== l[rx]) begin
          n_bad++; $display("FAIL bp_result[%0d]: got %h/%b want %h/%b", rx, out_data, out_last, exp_d[rx], l[rx]);
        end
        rx++;
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data; held_l = out_last;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (rx != 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", rx); end
    n_cmp++; if (saw_full !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_drop: got %b want 1", saw_full); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got busy=%b valid=%b want 0/0", busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d [16];
    logic [127:0] k [16];
    logic [127:0] exp_d [16];
    int rx, run, max_run;
    for (int i = 0; i < 16; i++) begin
      d[i] = {$urandom, $urandom, $urandom, $urandom};
      k[i] = {$urandom, $urandom, $urandom, $urandom};
      exp_d[i] = ref_round(d[i], k[i], 1'b0);
    end
    rx = 0; run = 0; max_run = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16 + LAT + 3; cyc++) begin
      @(negedge clk);
      if (cyc < 16) begin
        in_valid = 1'b1; in_data = d[cyc]; in_key = k[cyc]; in_last = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        n_cmp++;
        if (rx >= 16) begin
          n_bad++; $display("FAIL b2b_extra: got result %h want none", out_data);
        end else if (out_data !== exp_d[rx]) begin
          n_bad++; $display("FAIL b2b_result[%0d]: got %h want %h", rx, out_data, exp_d[rx]);
        end
        rx++;
      end else begin
        run = 0;
      end
    end
    n_cmp++; if (max_run != 16) begin n_bad++; $display("FAIL b2b_run: got %0d want 16", max_run); end
    n_cmp++; if (rx != 16) begin n_bad++; $display("FAIL b2b_count: got %0d want 16", rx); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] q; logic ql; int lat;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_last = 1'b1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got busy=%b valid=%b want 1/1", busy, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 128'h0) begin n_bad++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL midrst_out_last: got %b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_ready: got %b/%b want 0/1", busy, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    run_one(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, q, ql, lat);
    n_cmp++; if (q !== 128'ha49c7ff2689f352b6b5bea43026a5049 || lat != LAT) begin n_bad++; $display("FAIL midrst_resume: got %h lat %0d want a49c7ff2689f352b6b5bea43026a5049 lat %0d", q, lat, LAT); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_dup: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_fips_round();
    test_mixcolumns();
    test_shiftrows();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
